// File: rtl/shift_arb_if.sv
// shift_arb_if -- bundle of the two requester channels and the result channel
// of the shift_arb block.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1 on that channel. A requester raises valid without looking at ready
// and holds its operand until the transfer. Ready is a combinational function
// of valids, arbiter state and res_ready_i. Result data/id stay stable while
// res_valid_o=1 and res_ready_i=0.
//
// Signals:
//   reqN_valid_i / reqN_ready_o       requester N handshake (N = 0, 1)
//   reqN_data_i / reqN_shamt_i        requester N operand and shift amount
//   reqN_op_i                         00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   res_valid_o / res_ready_i         result handshake
//   res_data_o / res_id_o             shifted result and producing requester
//   state_dbg                         result register FSM (0 EMPTY, 1 FULL)
// Modports: master = requesters + consumer side, slave = shift_arb.
interface shift_arb_if #(
  parameter int WIDTH_P       = 32,
  parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P)
);
  logic                     req0_valid_i;
  logic                     req0_ready_o;
  logic [WIDTH_P-1:0]       req0_data_i;
  logic [SHAMT_WIDTH_P-1:0] req0_shamt_i;
  logic [1:0]               req0_op_i;

  logic                     req1_valid_i;
  logic                     req1_ready_o;
  logic [WIDTH_P-1:0]       req1_data_i;
  logic [SHAMT_WIDTH_P-1:0] req1_shamt_i;
  logic [1:0]               req1_op_i;

  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [WIDTH_P-1:0]       res_data_o;
  logic                     res_id_o;

  logic                     state_dbg;

  modport master (
    output req0_valid_i, req0_data_i, req0_shamt_i, req0_op_i,
    output req1_valid_i, req1_data_i, req1_shamt_i, req1_op_i,
    output res_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  res_valid_o, res_data_o, res_id_o, state_dbg
  );

  modport slave (
    input  req0_valid_i, req0_data_i, req0_shamt_i, req0_op_i,
    input  req1_valid_i, req1_data_i, req1_shamt_i, req1_op_i,
    input  res_ready_i,
    output req0_ready_o, req1_ready_o,
    output res_valid_o, res_data_o, res_id_o, state_dbg
  );
endinterface

// File: rtl/shift_arb.sv
// shift_arb -- two requesters share one combinational barrel shifter through
// a round-robin arbiter; the granted result lands in a one-entry output
// register (EMPTY/FULL FSM) with same-cycle drain and refill.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    shift_arb_if.slave: requester channels, result channel, FSM debug
module shift_arb #(
  parameter int WIDTH_P       = 32,
  parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  shift_arb_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     last_grant_q;
  logic [WIDTH_P-1:0]       res_data_q;
  logic                     res_id_q;

  logic                     accept_ok;
  logic                     grant;
  logic                     ready0, ready1;
  logic                     accept;

  logic [WIDTH_P-1:0]       op_data;
  logic [SHAMT_WIDTH_P-1:0] op_shamt;
  logic [1:0]               op_sel;
  logic [WIDTH_P-1:0]       shift_res;

  // Round-robin: on contention the requester not granted last wins;
  // otherwise whichever single requester is valid gets the grant.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid_i) begin
      grant = 1'b1;
    end
  end

  // Room exists when the register is empty or is being drained this cycle.
  assign accept_ok = (state_q == EMPTY) || bus.res_ready_i;

  // Readies are forced low while reset is held, even though the FSM is
  // already EMPTY at that point.
  assign ready0 = !rst_i && accept_ok && bus.req0_valid_i && (grant == 1'b0);
  assign ready1 = !rst_i && accept_ok && bus.req1_valid_i && (grant == 1'b1);
  assign accept = ready0 || ready1;

  // Single shared shifter fed by the granted requester's operands.
  always_comb begin
    op_data  = grant ? bus.req1_data_i  : bus.req0_data_i;
    op_shamt = grant ? bus.req1_shamt_i : bus.req0_shamt_i;
    op_sel   = grant ? bus.req1_op_i    : bus.req0_op_i;
    shift_res = op_data;
    case (op_sel)
      2'b00:   shift_res = op_data << op_shamt;
      2'b01:   shift_res = op_data >> op_shamt;
      2'b10:   shift_res = WIDTH_P'($signed(op_data) >>> op_shamt);
      default: shift_res = op_data;
    endcase
  end

  // Next-state logic for the result register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (bus.res_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and last-grant only move on an accepted transfer, which keeps
  // the result stable under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      res_data_q   <= shift_res;
      res_id_q     <= grant;
      last_grant_q <= grant;
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.res_valid_o  = (state_q == FULL);
  assign bus.res_data_o   = res_data_q;
  assign bus.res_id_o     = res_id_q;
  assign bus.state_dbg    = (state_q == FULL);

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb -- directed bench for shift_arb with hand-computed results.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_shift_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shift_arb_if #(.WIDTH_P(32), .SHAMT_WIDTH_P(5)) bus ();

  shift_arb #(.WIDTH_P(32), .SHAMT_WIDTH_P(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    bus.req0_valid_i = 1'b0;
    bus.req0_data_i  = '0;
    bus.req0_shamt_i = '0;
    bus.req0_op_i    = 2'b00;
    bus.req1_valid_i = 1'b0;
    bus.req1_data_i  = '0;
    bus.req1_shamt_i = '0;
    bus.req1_op_i    = 2'b00;
    bus.res_ready_i  = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bus.req0_valid_i = v;
    bus.req0_data_i  = d;
    bus.req0_shamt_i = s;
    bus.req0_op_i    = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bus.req1_valid_i = v;
    bus.req1_data_i  = d;
    bus.req1_shamt_i = s;
    bus.req1_op_i    = op;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    drive0(1'b1, 32'h1, 5'd0, 2'b11);
    drive1(1'b1, 32'h2, 5'd0, 2'b11);
    step();
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid_o); end
    checks++; if (bus.res_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.res_data_o); end
    checks++; if (bus.res_id_o !== 1'b0) begin errors++; $display("FAIL reset_id: got %b expected 0", bus.res_id_o); end
    checks++; if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready_o, bus.req1_ready_o); end
    idle_inputs();
    rst = 1'b0;
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", bus.res_valid_o); end
  endtask

  task automatic test_single();
    drive0(1'b1, 32'h0000_00F0, 5'd4, 2'b00);
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", bus.req0_ready_o); end
    step();
    drive0(1'b0, 32'h0, 5'd0, 2'b00);
    checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.res_valid_o); end
    checks++; if (bus.res_data_o !== 32'h0000_0F00) begin errors++; $display("FAIL single_data: got %h expected 00000f00", bus.res_data_o); end
    checks++; if (bus.res_id_o !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", bus.res_id_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus.res_valid_o); end
  endtask

  task automatic test_shift_right();
    drive1(1'b1, 32'h8000_0000, 5'd31, 2'b10);
    step();
    checks++; if (bus.res_data_o !== 32'hFFFF_FFFF || bus.res_id_o !== 1'b1) begin errors++; $display("FAIL sra_neg: got %h/%b expected ffffffff/1", bus.res_data_o, bus.res_id_o); end
    drive1(1'b1, 32'h8000_0000, 5'd31, 2'b01);
    step();
    checks++; if (bus.res_data_o !== 32'h0000_0001 || bus.res_id_o !== 1'b1) begin errors++; $display("FAIL srl: got %h/%b expected 00000001/1", bus.res_data_o, bus.res_id_o); end
    drive1(1'b1, 32'h7000_00F0, 5'd4, 2'b10);
    step();
    checks++; if (bus.res_data_o !== 32'h0700_000F) begin errors++; $display("FAIL sra_pos: got %h expected 0700000f", bus.res_data_o); end
    drive1(1'b0, 32'h0, 5'd0, 2'b00);
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL sr_drain: got %b expected 0", bus.res_valid_o); end
  endtask

  task automatic test_pass_zero();
    drive0(1'b1, 32'hDEAD_BEEF, 5'd17, 2'b11);
    // Non-valid requester 1 carries junk that must not leak into the result.
    drive1(1'b0, 32'h1234_0000, 5'd3, 2'b00);
    step();
    checks++; if (bus.res_data_o !== 32'hDEAD_BEEF || bus.res_id_o !== 1'b0) begin errors++; $display("FAIL pass: got %h/%b expected deadbeef/0", bus.res_data_o, bus.res_id_o); end
    drive0(1'b1, 32'h1234_5678, 5'd0, 2'b00);
    step();
    checks++; if (bus.res_data_o !== 32'h1234_5678) begin errors++; $display("FAIL sll_zero: got %h expected 12345678", bus.res_data_o); end
    drive0(1'b0, 32'h0, 5'd0, 2'b00);
    step();
  endtask

  task automatic test_contention();
    logic [31:0] exp_q[$];
    logic        exp_id;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    drive0(1'b1, 32'hA0, 5'd0, 2'b11);
    drive1(1'b1, 32'hB1, 5'd0, 2'b11);
    exp_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.req0_ready_o !== ~exp_id || bus.req1_ready_o !== exp_id) begin errors++; $display("FAIL cont_grant%0d: got %b%b expected %b%b", i, bus.req0_ready_o, bus.req1_ready_o, ~exp_id, exp_id); end
      exp_q.push_back(exp_id ? 32'hB1 : 32'hA0);
      step();
      checks++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== exp_id || bus.res_data_o !== exp_q.pop_front()) begin errors++; $display("FAIL cont_result%0d: got %b/%b/%h expected 1/%b", i, bus.res_valid_o, bus.res_id_o, bus.res_data_o, exp_id); end
      exp_id = ~exp_id;
    end
    drive0(1'b0, 32'h0, 5'd0, 2'b00);
    drive1(1'b0, 32'h0, 5'd0, 2'b00);
    step();
  endtask

  task automatic test_backpressure();
    drive0(1'b1, 32'h10, 5'd1, 2'b00);
    step();
    checks++; if (bus.res_data_o !== 32'h20) begin errors++; $display("FAIL bp_first: got %h expected 00000020", bus.res_data_o); end
    bus.res_ready_i = 1'b0;
    drive0(1'b1, 32'h30, 5'd1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", i, bus.req0_ready_o); end
      checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h20) begin errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/00000020", i, bus.res_valid_o, bus.res_data_o); end
      step();
    end
    bus.res_ready_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL bp_refill_ready: got %b expected 1", bus.req0_ready_o); end
    step();
    drive0(1'b0, 32'h0, 5'd0, 2'b00);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h60) begin errors++; $display("FAIL bp_next: got %b/%h expected 1/00000060", bus.res_valid_o, bus.res_data_o); end
    step();
  endtask

  task automatic test_reset_mid_op();
    // Leave requester 1 as last grant so a missing reset of it is visible.
    drive1(1'b1, 32'h55, 5'd0, 2'b11);
    bus.res_ready_i = 1'b0;
    step();
    drive1(1'b0, 32'h0, 5'd0, 2'b00);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.state_dbg !== 1'b1) begin errors++; $display("FAIL mid_full: got %b/%b expected 1/1", bus.res_valid_o, bus.state_dbg); end
    #2;
    rst = 1'b1;
    drive0(1'b1, 32'h66, 5'd0, 2'b11);
    drive1(1'b1, 32'h77, 5'd0, 2'b11);
    #1;
    checks++; if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== 32'h0) begin errors++; $display("FAIL mid_async: got %b/%h expected 0/00000000", bus.res_valid_o, bus.res_data_o); end
    checks++; if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b%b expected 00", bus.req0_ready_o, bus.req1_ready_o); end
    step();
    rst = 1'b0;
    bus.res_ready_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL mid_first_grant: got %b%b expected 10", bus.req0_ready_o, bus.req1_ready_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 1'b0 || bus.res_data_o !== 32'h66) begin errors++; $display("FAIL mid_first_result: got %b/%b/%h expected 1/0/00000066", bus.res_valid_o, bus.res_id_o, bus.res_data_o); end
    idle_inputs();
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_shift_right();
    test_pass_zero();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
